// File: rtl/approx_mult_pkg.sv
// Shared types and arithmetic for the approximate multiplier datapath.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package approx_mult_pkg;

  // Per-transaction arithmetic mode carried alongside the operands.
  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  // Widest operand the shared helper supports; callers truncate the result
  // to their own 2N-bit product width.
  localparam int MAX_N = 32;

  // Approximate low contribution A for the low L partial-product rows of
  // x*y. Rows are OR-combined in pairs (2k, 2k+1) column by column; an odd
  // trailing row passes through unchanged. Columns below T are dropped and
  // the surviving bits of every pair are summed with their column weight.
  // n, l and t must be elaboration-time constants when used in hardware.
  function automatic logic [2*MAX_N-1:0] approx_low_sum(
    input int                 n,
    input int                 l,
    input int                 t,
    input logic [MAX_N-1:0]   x,
    input logic [MAX_N-1:0]   y
  );
    logic [2*MAX_N-1:0] acc;
    logic [MAX_N-1:0]   xs;
    logic [MAX_N-1:0]   ys;
    logic               b;
    acc = '0;
    for (int i = 0; i < MAX_N; i += 2) begin
      if (i < l) begin
        xs = x >> i;
        for (int c = 0; c < 2 * MAX_N; c++) begin
          b = 1'b0;
          if ((c >= t) && (c < 2 * n)) begin
            // Even row of the pair: pp_i[c-i]
            if ((c - i >= 0) && (c - i < n)) begin
              ys = y >> (c - i);
              b  = b | (xs[0] & ys[0]);
            end
            // Odd row of the pair, absent when L is odd and i is the last row
            if ((i + 1 < l) && (c - i - 1 >= 0) && (c - i - 1 < n)) begin
              ys = y >> (c - i - 1);
              b  = b | (xs[1] & ys[0]);
            end
          end
          acc = acc + ({{(2*MAX_N-1){1'b0}}, b} << c);
        end
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/approx_low_rows.sv
// Low-row generator: approximate contribution A and exact low sum y*x[L-1:0].
// Latency: combinational, zero cycles.
// Backpressure: none; the caller registers the selected result.
module approx_low_rows
  import approx_mult_pkg::*;
#(
  parameter int N = 8,
  parameter int L = 4,
  parameter int T = 8
) (
  input  logic [L-1:0]   x_lo,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] approx_lo,
  output logic [2*N-1:0] exact_lo
);

  logic [MAX_N-1:0] x_ext;
  logic [MAX_N-1:0] y_ext;

  // Zero-extend operands to the helper width, then form both low sums.
  always_comb begin
    x_ext          = '0;
    y_ext          = '0;
    x_ext[L-1:0]   = x_lo;
    y_ext[N-1:0]   = y;
    approx_lo      = (2*N)'(approx_low_sum(N, L, T, x_ext, y_ext));
    exact_lo       = {{N{1'b0}}, y} * {{(2*N-L){1'b0}}, x_lo};
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined N x N unsigned multiplier, exact or truncate-and-OR approximate per transaction.
// Latency: STAGES cycles from input handshake to out_valid; one result per cycle.
// Backpressure: every stage stalls together while out_valid & ~out_ready; in_ready is that enable.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int N      = 8,
  parameter int L      = 4,
  parameter int T      = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_y,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_z,
  output logic             out_mode,
  output logic [CNT_W-1:0] approx_cnt
);

  // One pipeline slot. Stage 1 keeps the high product and low sum apart so
  // the wide final add lands in stage 2; from there on lo is always zero and
  // hi carries the finished product.
  typedef struct packed {
    logic           vld;
    mode_e          mode;
    logic [2*N-1:0] hi;
    logic [2*N-1:0] lo;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t           stg_q [STAGES];
  stage_t           stg_d [STAGES];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             en;
  logic             accept;
  logic [2*N-1:0]   hi_prod;
  logic [2*N-1:0]   lo_exact;
  logic [2*N-1:0]   lo_approx;
  logic [2*N-1:0]   lo_sel;

  approx_low_rows #(
    .N (N),
    .L (L),
    .T (T)
  ) u_low_rows (
    .x_lo      (in_x[L-1:0]),
    .y         (in_y),
    .approx_lo (lo_approx),
    .exact_lo  (lo_exact)
  );

  // A single global enable keeps bubbles in place and stalls every stage at once.
  assign out_valid  = stg_q[STAGES-1].vld;
  assign out_mode   = stg_q[STAGES-1].mode;
  assign out_z      = stg_q[STAGES-1].hi;
  assign en         = out_ready | ~out_valid;
  assign in_ready   = en;
  assign accept     = in_valid & en;
  assign approx_cnt = cnt_q;

  // High rows are always exact; the low rows follow the transaction's mode.
  always_comb begin
    hi_prod = ({{N{1'b0}}, in_y} * {{(N+L){1'b0}}, in_x[N-1:L]}) << L;
    lo_sel  = in_mode ? lo_approx : lo_exact;
  end

  // Next-state of the pipeline: load stage 1 on enable, shift and add downstream.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      stg_d[s] = stg_q[s];
    end
    if (en) begin
      stg_d[0].vld = in_valid;
      // Operand data is captured only on a real handshake; bubbles keep stale data.
      if (in_valid) begin
        stg_d[0].mode = mode_e'(in_mode);
        if (STAGES == 1) begin
          stg_d[0].hi = hi_prod + lo_sel;
          stg_d[0].lo = '0;
        end else begin
          stg_d[0].hi = hi_prod;
          stg_d[0].lo = lo_sel;
        end
      end
      for (int s = 1; s < STAGES; s++) begin
        stg_d[s].vld  = stg_q[s-1].vld;
        stg_d[s].mode = stg_q[s-1].mode;
        stg_d[s].hi   = stg_q[s-1].hi + stg_q[s-1].lo;
        stg_d[s].lo   = '0;
      end
    end
  end

  // Saturating count of accepted approximate transactions.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && in_mode && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        stg_q[s] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        stg_q[s] <= stg_d[s];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
